// File: rtl/instruction_sequencer.sv
// Purpose : program store + in-order issue stage feeding the CPU core's 32-bit current_instruction.
// Latency : first word one edge after start_in (two with SEQUENCER_RESET_INJECT_EN), then 1 word/cycle.
// Backpressure: none; NOP bubbles are inserted after each tensor-core operate (opcode 8'h05).
// Optional feature macro: SEQUENCER_RESET_INJECT_EN -- issue one RESET word before mem[0] on every start.
module instruction_sequencer #(
    parameter int ADDR_WIDTH           = 6,
    parameter int OPERATE_STALL_CYCLES = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  load_valid_in,
    input  logic [ADDR_WIDTH-1:0] load_address_in,
    input  logic [31:0]           load_data_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    output logic [31:0]           current_instruction_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int          LW         = ADDR_WIDTH + 1;
    localparam int          DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0008;
    localparam logic [31:0] RESET_WORD = 32'h0000_000D;
    localparam logic [7:0]  OP_CODE    = 8'h05;
    // Counter is loaded with N-1 when the first bubble is already on the output.
    localparam logic [3:0]  STALL_LOAD = (OPERATE_STALL_CYCLES > 0) ?
                                         4'(OPERATE_STALL_CYCLES - 1) : 4'd0;

`ifdef SEQUENCER_RESET_INJECT_EN
    typedef enum logic [2:0] {S_IDLE, S_INJECT, S_RUN, S_STALL, S_FINISH} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STALL, S_FINISH} state_t;
`endif

    // r_state names what is on the output during the current cycle.
    state_t        r_state;
    logic [LW-1:0] r_pc;       // one bit wider than the address so a full-depth program ends cleanly
    logic [LW-1:0] r_len;
    logic [3:0]    r_cnt;
    logic [31:0]   r_instr;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_mem [DEPTH];

    logic          w_load_ok;
    logic [LW-1:0] w_load_end;
    logic [LW-1:0] w_pc_inc;
    logic [31:0]   w_word;
    logic          w_is_op;

    assign w_load_ok  = load_valid_in && (r_state == S_IDLE) && !start_in;
    assign w_load_end = LW'(load_address_in) + LW'(1);
    assign w_pc_inc   = r_pc + LW'(1);
    assign w_word     = r_mem[r_pc[ADDR_WIDTH-1:0]];
    assign w_is_op    = (r_instr[7:0] == OP_CODE);

    // Instruction store: written only by accepted loads, never cleared.
    always_ff @(posedge clock_in) begin
        if (w_load_ok) begin
            r_mem[load_address_in] <= load_data_in;
        end
    end

    // Issue FSM with registered instruction, pc, busy and done.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_instr <= NOP_WORD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_ok && (w_load_end > r_len)) begin
                r_len <= w_load_end;
            end
            if (abort_in && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_instr <= NOP_WORD;
                r_pc    <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_in) begin
                            r_busy <= 1'b1;
                            if (r_len == '0) begin
                                r_state <= S_FINISH;
                                r_instr <= NOP_WORD;
                                r_done  <= 1'b1;
                            end else begin
`ifdef SEQUENCER_RESET_INJECT_EN
                                r_state <= S_INJECT;
                                r_instr <= RESET_WORD;
`else
                                r_state <= S_RUN;
                                r_instr <= w_word;
                                r_pc    <= w_pc_inc;
`endif
                            end
                        end
                    end
`ifdef SEQUENCER_RESET_INJECT_EN
                    S_INJECT: begin
                        r_state <= S_RUN;
                        r_instr <= w_word;
                        r_pc    <= w_pc_inc;
                    end
`endif
                    S_RUN: begin
                        if (w_is_op && (OPERATE_STALL_CYCLES > 0)) begin
                            r_state <= S_STALL;
                            r_instr <= NOP_WORD;
                            r_cnt   <= STALL_LOAD;
                        end else if (r_pc == r_len) begin
                            r_state <= S_FINISH;
                            r_instr <= NOP_WORD;
                            r_done  <= 1'b1;
                        end else begin
                            r_instr <= w_word;
                            r_pc    <= w_pc_inc;
                        end
                    end
                    S_STALL: begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else if (r_pc == r_len) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_instr <= w_word;
                            r_pc    <= w_pc_inc;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        r_instr <= NOP_WORD;
                        r_pc    <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_instr <= NOP_WORD;
                        r_pc    <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign current_instruction_out = r_instr;
    assign pc_out                  = r_pc[ADDR_WIDTH-1:0];
    assign busy_out                = r_busy;
    assign done_out                = r_done;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer (ADDR_WIDTH=6, OPERATE_STALL_CYCLES=4).
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
// Expectations follow SEQUENCER_RESET_INJECT_EN when the bench is built with it.
module tb_instruction_sequencer;

    localparam logic [31:0] NOP  = 32'h0000_0008;
    localparam logic [31:0] RSTW = 32'h0000_000D;
    localparam logic [31:0] ADD  = 32'h0302_0100;
    localparam logic [31:0] SUB  = 32'h0403_0201;
    localparam logic [31:0] OPW  = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        abort;
    logic [31:0] instr;
    logic [5:0]  pc;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    instruction_sequencer #(.ADDR_WIDTH(6), .OPERATE_STALL_CYCLES(4)) dut (
        .clock_in                (clk),
        .reset_in                (rst),
        .load_valid_in           (load_valid),
        .load_address_in         (load_addr),
        .load_data_in            (load_data),
        .start_in                (start),
        .abort_in                (abort),
        .current_instruction_out (instr),
        .pc_out                  (pc),
        .busy_out                (busy),
        .done_out                (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs of one cycle: instruction, pc, busy, done.
    task automatic chk_cycle(input string tag, input logic [31:0] e_i, input int e_pc,
                             input logic e_busy, input logic e_done);
        chk({tag, ".instr"}, instr, e_i);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    // Pulse start on a non-empty program; returns with mem[0] on the output.
    task automatic start_prog(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SEQUENCER_RESET_INJECT_EN
        chk_cycle({tag, ".inject"}, RSTW, 0, 1'b1, 1'b0);
        tick();
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] full_word(input int i);
        return {16'hA5A5, 8'(i), 8'h10};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0;
        #1;
        chk_cycle("reset", NOP, 0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Three-word program issued back to back.
        load(6'd0, ADD);
        load(6'd1, SUB);
        load(6'd2, NOP);
        start_prog("p3");
        chk_cycle("p3.c1", ADD, 1, 1'b1, 1'b0);
        tick(); chk_cycle("p3.c2", SUB, 2, 1'b1, 1'b0);
        tick(); chk_cycle("p3.c3", NOP, 3, 1'b1, 1'b0);
        tick(); chk_cycle("p3.c4", NOP, 3, 1'b1, 1'b1);
        tick(); chk_cycle("p3.c5", NOP, 0, 1'b0, 1'b0);

        // Operate followed by four bubbles.
        do_reset();
        load(6'd0, OPW);
        load(6'd1, ADD);
        start_prog("op");
        chk_cycle("op.c1", OPW, 1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_cycle($sformatf("op.stall%0d", i), NOP, 1, 1'b1, 1'b0);
        end
        tick(); chk_cycle("op.add", ADD, 2, 1'b1, 1'b0);
        tick(); chk_cycle("op.done", NOP, 2, 1'b1, 1'b1);
        tick(); chk_cycle("op.idle", NOP, 0, 1'b0, 1'b0);

        // Empty program finishes on the next cycle.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("empty.c1", NOP, 0, 1'b1, 1'b1);
        tick(); chk_cycle("empty.c2", NOP, 0, 1'b0, 1'b0);

        // Abort in the second stall cycle; then a full rerun with stray load/start while busy.
        load(6'd0, OPW);
        load(6'd1, ADD);
        start_prog("ab");
        chk_cycle("ab.c1", OPW, 1, 1'b1, 1'b0);
        tick(); tick();
        chk_cycle("ab.stall2", NOP, 1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_cycle("ab.after", NOP, 0, 1'b0, 1'b0);
        tick(); chk_cycle("ab.nodone", NOP, 0, 1'b0, 1'b0);
        start_prog("re");
        chk_cycle("re.c1", OPW, 1, 1'b1, 1'b0);
        tick();
        load_valid = 1'b1; load_addr = 6'd10; load_data = SUB; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        tick(); tick();
        chk_cycle("re.stall4", NOP, 1, 1'b1, 1'b0);
        tick(); chk_cycle("re.add", ADD, 2, 1'b1, 1'b0);
        tick(); chk_cycle("re.done", NOP, 2, 1'b1, 1'b1);
        tick(); chk_cycle("re.idle", NOP, 0, 1'b0, 1'b0);
        // Dropped load must leave the length at two words.
        start_prog("len");
        chk_cycle("len.c1", OPW, 1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        tick(); chk_cycle("len.add", ADD, 2, 1'b1, 1'b0);
        tick(); chk_cycle("len.done", NOP, 2, 1'b1, 1'b1);
        tick();

        // Full-depth program: 64 words, ending after address 63.
        do_reset();
        for (int i = 0; i < 64; i++) load(6'(i), full_word(i));
        start_prog("full");
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("full.w%0d", i), instr, full_word(i));
            chk($sformatf("full.pc%0d", i), 32'(pc), 32'((i + 1) % 64));
            tick();
        end
        chk("full.done", 32'(done), 32'd1);
        chk("full.instr_end", instr, NOP);
        tick();
        chk("full.busy_end", 32'(busy), 32'd0);

        // Asynchronous reset mid-run clears outputs before the next edge and empties len.
        start_prog("mr");
        tick(); tick();
        chk("mr.running", instr, full_word(2));
        #2;
        rst = 1'b1;
        #1;
        chk_cycle("mr.async", NOP, 0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_cycle("mr.held", NOP, 0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cycle("mr.lenzero", NOP, 0, 1'b1, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

- Program-store and issue stage that sits directly upstream of the CPU core and drives its 32-bit `current_instruction` input once per clock.
- A host loads a program word-by-word into an internal instruction memory, then pulses start. The block issues the program in order.
- It inserts NOP bubbles after every tensor-core operate instruction so the tensor core can finish before the next instruction arrives.
- It signals completion when the last loaded word has been issued.

## Interface
Parameters:
- `ADDR_WIDTH`, 6 — instruction memory depth is 2**ADDR_WIDTH 32-bit words.
- `OPERATE_STALL_CYCLES`, 4 — NOP bubbles inserted after a tensor-core operate (opcode 8'h05). Legal range 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clock_in`  input  1  — system clock, rising edge.
- `reset_in`  input  1  — asynchronous, active-high reset.
- `load_valid_in`  input  1  — write `load_data_in` to memory this cycle.
- `load_address_in`  input  ADDR_WIDTH  — memory write address.
- `load_data_in`  input  32  — instruction word to store.
- `start_in`  input  1  — begin issuing from address 0.
- `abort_in`  input  1  — stop issuing immediately.
- `current_instruction_out`  output  32  — registered instruction to the CPU.
- `pc_out`  output  ADDR_WIDTH  — address of the next word to issue.
- `busy_out`  output  1  — high while not IDLE.
- `done_out`  output  1  — one-cycle pulse when the program completes.

## Operation
- NOP word: 32'h0000_0008. RESET word: 32'h0000_000D. Operate opcode: bits [7:0] == 8'h05.
- Program length register `len`, ADDR_WIDTH+1 bits:
  - An accepted load sets `len` to max(`len`, `load_address_in`+1).
  - A load is accepted only in IDLE, and only when `start_in` is low.
  - Loads in any other state or cycle are dropped silently.
- States: IDLE, INJECT, RUN, STALL, FINISH.
- IDLE:
  - Output NOP, `pc_out` = 0.
  - `start_in` with `len`≠0 goes to INJECT (macro defined) or RUN (macro undefined).
  - `start_in` with `len`==0 goes to FINISH.
- INJECT: output the RESET word for exactly one cycle, then go to RUN.
- RUN:
  - Output mem[pc] and increment pc.
  - If the issued word is an operate and OPERATE_STALL_CYCLES>0, go to STALL and load the stall counter.
  - Otherwise, if the incremented pc == `len`, go to FINISH.
- STALL:
  - Output NOP and hold pc; decrement the counter.
  - When it reaches zero, go to RUN, or to FINISH if pc == `len`.
- FINISH: output NOP, assert `done_out` for one cycle, then go to IDLE.
- `abort_in` in any non-IDLE state:
  - Next cycle is IDLE with NOP output and pc = 0.
  - `done_out` is not pulsed.
  - `abort_in` has priority over every other transition.
- `start_in` while busy is ignored. Memory contents survive abort and complete runs.
- PC wrap: `len` is at most 2**ADDR_WIDTH, so pc never wraps. A full-depth program ends after address 2**ADDR_WIDTH-1.

## Timing
- Reset values:
  - `current_instruction_out` = NOP.
  - `pc_out` = 0, `busy_out` = 0, `done_out` = 0.
  - State = IDLE, `len` = 0, stall counter = 0.
  - Memory is not cleared.
- Reset asserted mid-run forces these values asynchronously, with no further instructions issued.
- Start latency:
  - Macro defined: the RESET word appears on the first edge after the `start_in` cycle, and mem[0] on the second.
  - Macro undefined: mem[0] appears on the first edge after `start_in`.
- Throughput is one word per cycle in RUN.
- An operate at address k is followed by exactly OPERATE_STALL_CYCLES NOP cycles, then mem[k+1].
- `done_out` is high in the cycle after the last non-NOP issue, or after the last stall NOP if the final word is an operate. `busy_out` falls in the following cycle.
- Memory read is synchronous from `pc`. Output is registered; no combinational path from inputs to outputs.

## Configuration
- `SEQUENCER_RESET_INJECT_EN`:
  - Defined: every start issues one RESET word (32'h0000_000D) before mem[0], clearing CPU and tensor-core register files.
  - Undefined: the INJECT state is absent, and start goes directly to RUN (or to FINISH when `len`==0).

## Test plan
- Load 3 words (ADD 32'h0302_0100, SUB 32'h0403_0201, NOP), start, macro undefined → 3 words issued on consecutive cycles; `done_out` pulses in cycle 4; `busy_out` is low from cycle 5.
- Load operate 32'h0000_0005 at address 0 and ADD at address 1, OPERATE_STALL_CYCLES=4 → sequence 05, NOP×4, ADD, then `done_out`.
- Macro defined, 1-word program → outputs RESET word, then mem[0], then `done_out`.
- Start with `len`==0 → `done_out` pulses on the next cycle; only NOPs issued.
- Abort during STALL (cycle 2 of 4) → NOP next cycle, `pc_out`=0, no `done_out`; a restart re-issues from address 0.
- Load at address 63 (ADDR_WIDTH=6) → 64 words issued with no wrap. `reset_in` asserted mid-run → output is NOP immediately; `len`=0.
